hsv_adjust_pipe: RTL and testbench

//  Streaming HSV adjustment stage: hue rotation (mod H_MAX), signed-percentage saturation and

---
 rtl/hsv_adjust_pipe_if.sv | 28 ++
 rtl/hsv_adjust_pipe.sv | 183 ++++++++++++++++++
 tb/tb_hsv_adjust_pipe.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/hsv_adjust_pipe_if.sv
// rtl/hsv_adjust_pipe_if.sv - pixel stream bundle (HSV in, adjusted HSV out) for hsv_adjust_pipe
interface hsv_adjust_pipe_if #(
    parameter int H_W = 9,
    parameter int S_W = 11,
    parameter int V_W = 8
);
    logic           in_valid;
    logic           in_sof;
    logic [H_W-1:0] H_in;
    logic [S_W-1:0] S_in;
    logic [V_W-1:0] V_in;

    logic           out_valid;
    logic           out_sof;
    logic [H_W-1:0] H_out;
    logic [S_W-1:0] S_out;
    logic [V_W-1:0] V_out;

    modport master (
        output in_valid, in_sof, H_in, S_in, V_in,
        input  out_valid, out_sof, H_out, S_out, V_out
    );

    modport slave (
        input  in_valid, in_sof, H_in, S_in, V_in,
        output out_valid, out_sof, H_out, S_out, V_out
    );
endinterface

// File: rtl/hsv_adjust_pipe.sv
// rtl/hsv_adjust_pipe.sv - 4-stage HSV adjust: hue rotate mod H_MAX, S/V signed percent gain with clamp
module hsv_adjust_pipe #(
    parameter int H_W      = 9,
    parameter int S_W      = 11,
    parameter int V_W      = 8,
    parameter int H_MAX    = 360,
    parameter int RECIP    = 1311,
    parameter int RECIP_SH = 17
) (
    input  logic                 clk,
    input  logic                 reset_n,
    hsv_adjust_pipe_if.slave     pix,
    input  logic [8:0]           control_H,
    input  logic [8:0]           control_S,
    input  logic [8:0]           control_V,
    input  logic                 bypass
);
    localparam int RW    = $clog2(RECIP + 1);
    localparam int PS_W  = S_W + 8;
    localparam int PV_W  = V_W + 8;
    localparam int PSR_W = PS_W + RW;
    localparam int PVR_W = PV_W + RW;
    localparam int DS_W  = PSR_W - RECIP_SH;
    localparam int DV_W  = PVR_W - RECIP_SH;
    localparam int ES_W  = ((DS_W > S_W) ? DS_W : S_W) + 1;
    localparam int EV_W  = ((DV_W > V_W) ? DV_W : V_W) + 1;
    localparam logic [S_W-1:0] S_MAX = '1;
    localparam logic [V_W-1:0] V_MAX = '1;

    // Frame-atomic control set; loaded only by a valid start-of-frame pixel
    logic [8:0] act_h, act_s, act_v;
    logic       act_byp;

    logic       load;
    logic [8:0] sel_h, sel_s, sel_v;
    logic       sel_byp;
    logic [H_W-1:0] sel_mh;

    logic           s1_valid, s1_sof, s1_nh, s1_ns, s1_nv, s1_byp;
    logic [H_W-1:0] s1_h, s1_mh;
    logic [S_W-1:0] s1_s;
    logic [V_W-1:0] s1_v;
    logic [7:0]     s1_ms, s1_mv;

    logic            s2_valid, s2_sof, s2_nh, s2_ns, s2_nv, s2_byp;
    logic [H_W-1:0]  s2_h, s2_mh;
    logic [S_W-1:0]  s2_s;
    logic [V_W-1:0]  s2_v;
    logic [PS_W-1:0] s2_ps;
    logic [PV_W-1:0] s2_pv;

    logic            s3_valid, s3_sof, s3_ns, s3_nv, s3_byp;
    logic [H_W-1:0]  s3_h, s3_hadj;
    logic [S_W-1:0]  s3_s;
    logic [V_W-1:0]  s3_v;
    logic [DS_W-1:0] s3_ds;
    logic [DV_W-1:0] s3_dv;

    logic [PSR_W-1:0] prod_s;
    logic [PVR_W-1:0] prod_v;
    logic [H_W:0]     h_sum;
    logic [H_W-1:0]   h_next;
    logic [ES_W-1:0]  es, ed, es_sum;
    logic [EV_W-1:0]  ev, edv, ev_sum;
    logic [S_W-1:0]   s_next;
    logic [V_W-1:0]   v_next;

    always_comb begin
        load    = pix.in_valid & pix.in_sof;
        sel_h   = load ? control_H : act_h;
        sel_s   = load ? control_S : act_s;
        sel_v   = load ? control_V : act_v;
        sel_byp = load ? bypass    : act_byp;
        sel_mh  = H_W'(32'(sel_h[7:0]) % H_MAX);
    end

    // Stage-3 helpers: reciprocal divide-by-100 and hue wrap
    always_comb begin
        prod_s = PSR_W'(s2_ps) * PSR_W'(RECIP);
        prod_v = PVR_W'(s2_pv) * PVR_W'(RECIP);
        h_sum  = '0;
        h_next = s2_h;
        if ({1'b0, s2_h} < (H_W+1)'(H_MAX)) begin
            if (!s2_nh) begin
                h_sum = {1'b0, s2_h} + {1'b0, s2_mh};
                if (h_sum >= (H_W+1)'(H_MAX))
                    h_sum = h_sum - (H_W+1)'(H_MAX);
            end else if (s2_h < s2_mh) begin
                h_sum = {1'b0, s2_h} + (H_W+1)'(H_MAX) - {1'b0, s2_mh};
            end else begin
                h_sum = {1'b0, s2_h} - {1'b0, s2_mh};
            end
            h_next = H_W'(h_sum);
        end
    end

    // Stage-4 helpers: signed add with two-sided clamp
    always_comb begin
        es     = ES_W'(s3_s);
        ed     = ES_W'(s3_ds);
        es_sum = es + ed;
        ev     = EV_W'(s3_v);
        edv    = EV_W'(s3_dv);
        ev_sum = ev + edv;
        if (s3_ns)
            s_next = (ed > es) ? '0 : S_W'(es - ed);
        else
            s_next = (es_sum > ES_W'(S_MAX)) ? S_MAX : S_W'(es_sum);
        if (s3_nv)
            v_next = (edv > ev) ? '0 : V_W'(ev - edv);
        else
            v_next = (ev_sum > EV_W'(V_MAX)) ? V_MAX : V_W'(ev_sum);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_h <= '0; act_s <= '0; act_v <= '0; act_byp <= 1'b0;
            s1_valid <= 1'b0; s1_sof <= 1'b0; s1_nh <= 1'b0; s1_ns <= 1'b0;
            s1_nv <= 1'b0; s1_byp <= 1'b0; s1_h <= '0; s1_mh <= '0;
            s1_s <= '0; s1_v <= '0; s1_ms <= '0; s1_mv <= '0;
            s2_valid <= 1'b0; s2_sof <= 1'b0; s2_nh <= 1'b0; s2_ns <= 1'b0;
            s2_nv <= 1'b0; s2_byp <= 1'b0; s2_h <= '0; s2_mh <= '0;
            s2_s <= '0; s2_v <= '0; s2_ps <= '0; s2_pv <= '0;
            s3_valid <= 1'b0; s3_sof <= 1'b0; s3_ns <= 1'b0; s3_nv <= 1'b0;
            s3_byp <= 1'b0; s3_h <= '0; s3_hadj <= '0; s3_s <= '0; s3_v <= '0;
            s3_ds <= '0; s3_dv <= '0;
            pix.out_valid <= 1'b0; pix.out_sof <= 1'b0;
            pix.H_out <= '0; pix.S_out <= '0; pix.V_out <= '0;
        end else begin
            if (load) begin
                act_h   <= control_H;
                act_s   <= control_S;
                act_v   <= control_V;
                act_byp <= bypass;
            end

            // A set sign bit with zero magnitude is +0
            s1_valid <= pix.in_valid;
            s1_sof   <= pix.in_sof;
            s1_h     <= pix.H_in;
            s1_s     <= pix.S_in;
            s1_v     <= pix.V_in;
            s1_mh    <= sel_mh;
            s1_nh    <= sel_h[8] & (|sel_mh);
            s1_ms    <= sel_s[7:0];
            s1_ns    <= sel_s[8] & (|sel_s[7:0]);
            s1_mv    <= sel_v[7:0];
            s1_nv    <= sel_v[8] & (|sel_v[7:0]);
            s1_byp   <= sel_byp;

            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_h     <= s1_h;
            s2_mh    <= s1_mh;
            s2_nh    <= s1_nh;
            s2_s     <= s1_s;
            s2_v     <= s1_v;
            s2_ns    <= s1_ns;
            s2_nv    <= s1_nv;
            s2_byp   <= s1_byp;
            s2_ps    <= PS_W'(s1_s) * PS_W'(s1_ms);
            s2_pv    <= PV_W'(s1_v) * PV_W'(s1_mv);

            s3_valid <= s2_valid;
            s3_sof   <= s2_sof;
            s3_h     <= s2_h;
            s3_hadj  <= h_next;
            s3_s     <= s2_s;
            s3_v     <= s2_v;
            s3_ns    <= s2_ns;
            s3_nv    <= s2_nv;
            s3_byp   <= s2_byp;
            s3_ds    <= DS_W'(prod_s >> RECIP_SH);
            s3_dv    <= DV_W'(prod_v >> RECIP_SH);

            pix.out_valid <= s3_valid;
            pix.out_sof   <= s3_sof;
            pix.H_out     <= s3_byp ? s3_h : s3_hadj;
            pix.S_out     <= s3_byp ? s3_s : s_next;
            pix.V_out     <= s3_byp ? s3_v : v_next;
        end
    end
endmodule

// File: tb/tb_hsv_adjust_pipe.sv
// tb/tb_hsv_adjust_pipe.sv - bench for hsv_adjust_pipe: directed corner cases plus random stream vs model
module tb_hsv_adjust_pipe;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [8:0] control_H = '0, control_S = '0, control_V = '0;
    logic       bypass = 1'b0;

    hsv_adjust_pipe_if #(.H_W(9), .S_W(11), .V_W(8)) pix();

    hsv_adjust_pipe dut (
        .clk(clk), .reset_n(reset_n), .pix(pix),
        .control_H(control_H), .control_S(control_S), .control_V(control_V),
        .bypass(bypass)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit vld; bit sof; int h; int s; int v; int kh; int ks; int kv;
    } exp_t;

    exp_t q[$];
    int   npass = 0, ntot = 0, nfail = 0;
    int   m_ch = 0, m_cs = 0, m_cv = 0;
    bit   m_byp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        ntot++;
        assert (got === 32'(exp)) npass++;
        else begin
            nfail++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Percent gain: x +/- floor(x*pct*1311 / 2^17), clamped to [0, maxv]
    function automatic int adj_sv(input int x, input int c, input int maxv);
        int m, d, r;
        bit neg;
        m   = c & 255;
        neg = ((c >> 8) & 1) == 1 && m != 0;
        d   = int'((longint'(x) * longint'(m) * 64'd1311) >> 17);
        r   = neg ? x - d : x + d;
        if (r < 0) r = 0;
        if (r > maxv) r = maxv;
        return r;
    endfunction

    function automatic int adj_h(input int h, input int c);
        int m;
        m = (c & 255) % 360;
        if (h >= 360) return h;
        if (((c >> 8) & 1) == 1) return (h - m + 360) % 360;
        return (h + m) % 360;
    endfunction

    task automatic prefill();
        exp_t e;
        e = '{0, 0, 0, 0, 0, -1, -1, -1};
        q.delete();
        repeat (4) q.push_back(e);
        m_ch = 0; m_cs = 0; m_cv = 0; m_byp = 0;
    endtask

    task automatic check_out();
        exp_t e;
        e = q.pop_front();
        chk("out_valid", pix.out_valid, int'(e.vld));
        chk("out_sof", pix.out_sof, int'(e.sof));
        if (e.vld) begin
            chk("H_out", pix.H_out, e.h);
            chk("S_out", pix.S_out, e.s);
            chk("V_out", pix.V_out, e.v);
            if (e.kh >= 0) chk("H_out_directed", pix.H_out, e.kh);
            if (e.ks >= 0) chk("S_out_directed", pix.S_out, e.ks);
            if (e.kv >= 0) chk("V_out_directed", pix.V_out, e.kv);
        end
    endtask

    task automatic send(input bit vld, input bit sof, input int h, input int s, input int v,
                        input int ch, input int cs, input int cv, input bit byp,
                        input int kh = -1, input int ks = -1, input int kv = -1);
        exp_t e;
        @(negedge clk);
        check_out();
        pix.in_valid = vld;
        pix.in_sof   = sof;
        pix.H_in     = 9'(h);
        pix.S_in     = 11'(s);
        pix.V_in     = 8'(v);
        control_H    = 9'(ch);
        control_S    = 9'(cs);
        control_V    = 9'(cv);
        bypass       = byp;
        if (vld && sof) begin
            m_ch = ch; m_cs = cs; m_cv = cv; m_byp = byp;
        end
        e.vld = vld; e.sof = sof; e.kh = kh; e.ks = ks; e.kv = kv;
        if (m_byp) begin
            e.h = h; e.s = s; e.v = v;
        end else begin
            e.h = adj_h(h, m_ch);
            e.s = adj_sv(s, m_cs, 2047);
            e.v = adj_sv(v, m_cv, 255);
        end
        q.push_back(e);
    endtask

    task automatic idle();
        send(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int npix;
        pix.in_valid = 1'b0; pix.in_sof = 1'b0;
        pix.H_in = '0; pix.S_in = '0; pix.V_in = '0;
        #12;
        chk("reset_out_valid", pix.out_valid, 0);
        chk("reset_out_sof", pix.out_sof, 0);
        chk("reset_H_out", pix.H_out, 0);
        chk("reset_S_out", pix.S_out, 0);
        chk("reset_V_out", pix.V_out, 0);
        @(negedge clk);
        reset_n = 1'b1;
        prefill();

        // identity before any sof
        send(1, 0, 123, 999, 77, 'h014, 'h032, 'h032, 0, 123, 999, 77);
        // saturation +50%
        send(1, 1, 100, 1000, 100, 0, 'h032, 0, 0, -1, 1500, -1);
        // value -25%, +50% saturating, -150% floored
        send(1, 1, 0, 0, 200, 0, 0, 'h119, 0, -1, -1, 150);
        send(1, 1, 0, 0, 200, 0, 0, 'h032, 0, -1, -1, 255);
        send(1, 1, 0, 0, 100, 0, 0, 'h196, 0, -1, -1, 0);
        // hue wrap both directions, out-of-range hue untouched
        send(1, 1, 350, 0, 0, 'h014, 0, 0, 0, 10, -1, -1);
        send(1, 1, 5, 0, 0, 'h10A, 0, 0, 0, 355, -1, -1);
        send(1, 0, 400, 0, 0, 0, 0, 0, 0, 400, -1, -1);
        // saturation overflow clamps to all-ones
        send(1, 1, 0, 2000, 0, 0, 'h0FF, 0, 0, -1, 2047, -1);
        // mid-frame control change ignored until next sof
        send(1, 1, 10, 800, 10, 0, 0, 0, 0, -1, 800, -1);
        send(1, 0, 10, 800, 10, 0, 'h032, 0, 0, -1, 800, -1);
        idle();
        send(1, 0, 10, 800, 10, 0, 'h032, 0, 0, -1, 800, -1);
        send(0, 1, 10, 800, 10, 0, 'h064, 0, 0);
        send(1, 0, 10, 800, 10, 0, 'h064, 0, 0, -1, 800, -1);
        send(1, 1, 10, 800, 10, 0, 'h032, 0, 0, -1, 1200, -1);
        // negative sign with zero magnitude is +0
        send(1, 1, 20, 500, 50, 'h100, 'h100, 'h100, 0, 20, 500, 50);

        npix = 0;
        while (npix < 10000) begin
            bit vld, sof;
            vld = ($urandom_range(0, 9) < 7);
            sof = ($urandom_range(0, 19) == 0);
            send(vld, sof, $urandom_range(0, 511), $urandom_range(0, 2047), $urandom_range(0, 255),
                 $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511),
                 ($urandom_range(0, 9) == 0));
            if (vld) npix++;
        end

        // reset mid-frame drops in-flight pixels
        send(1, 1, 30, 300, 30, 'h005, 'h005, 'h005, 0);
        send(1, 0, 31, 301, 31, 0, 0, 0, 0);
        send(1, 0, 32, 302, 32, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        pix.in_valid = 1'b0;
        pix.in_sof = 1'b0;
        #1;
        chk("midreset_out_valid", pix.out_valid, 0);
        chk("midreset_out_sof", pix.out_sof, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        prefill();
        // controls return to identity until the next sof
        send(1, 0, 200, 1000, 100, 'h014, 'h032, 'h032, 1, 200, 1000, 100);
        idle();
        // bypass ignores controls
        send(1, 1, 300, 1234, 77, 'h0FF, 'h1FF, 'h0FF, 1, 300, 1234, 77);
        send(1, 0, 359, 2047, 255, 0, 0, 0, 0, 359, 2047, 255);
        send(1, 1, 300, 1234, 77, 'h0FF, 'h0FF, 'h0FF, 0, 195, 2047, 255);
        repeat (5) idle();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
